// File: rtl/code_entry_if.sv
// Valid/ready link carrying a submitted guess code from the entry block
// to the downstream comparator.
interface code_entry_if #(
  parameter int CODE_W = 16
);
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code_out;

  modport master (output code_valid, output code_out, input code_ready);
  modport slave  (input code_valid, input code_out, output code_ready);
endinterface

// File: rtl/code_entry.sv
// Guess-code entry: edits digits from debounced button pulses, submits the
// code over a valid/ready link, and locks after a bounded number of attempts.
module code_entry #(
  parameter int DIGITS       = 4,
  parameter int DIGIT_W      = 4,
  parameter int MAX_DIGIT    = 9,
  parameter int MAX_ATTEMPTS = 10,
  parameter int POS_W        = 2,
  parameter int ATT_W        = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inc_pulse_i,
  input  logic                        next_pulse_i,
  input  logic                        enter_pulse_i,
  input  logic                        clear_pulse_i,
  code_entry_if.master                code_if,
  output logic [DIGITS*DIGIT_W-1:0]   live_digits_o,
  output logic [POS_W-1:0]            cursor_o,
  output logic [ATT_W-1:0]            attempts_o,
  output logic                        locked_o
);

  localparam int CODE_W = DIGITS * DIGIT_W;

  localparam logic [1:0] ST_EDIT   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [CODE_W-1:0] digits_q,   digits_d;
  logic [CODE_W-1:0] code_q,     code_d;
  logic              valid_q,    valid_d;
  logic [POS_W-1:0]  cursor_q,   cursor_d;
  logic [ATT_W-1:0]  attempts_q, attempts_d;
  logic              locked_q,   locked_d;

  logic [CODE_W-1:0] digits_inc;
  logic [POS_W-1:0]  cursor_adv;
  logic [ATT_W-1:0]  attempts_inc;

  // Only the digit under the cursor changes; out-of-range values also wrap to 0.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [DIGIT_W-1:0] cur;
    logic [DIGIT_W-1:0] wrapped;
    assign cur     = digits_q[gi*DIGIT_W +: DIGIT_W];
    assign wrapped = (cur >= DIGIT_W'(MAX_DIGIT)) ? '0 : cur + DIGIT_W'(1);
    assign digits_inc[gi*DIGIT_W +: DIGIT_W] =
      (cursor_q == POS_W'(gi)) ? wrapped : cur;
  end

  assign cursor_adv   = (cursor_q == POS_W'(DIGITS - 1)) ? '0 : cursor_q + POS_W'(1);
  assign attempts_inc = attempts_q + ATT_W'(1);

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    code_d     = code_q;
    valid_d    = valid_q;
    cursor_d   = cursor_q;
    attempts_d = attempts_q;
    locked_d   = locked_q;

    case (state_q)
      ST_EDIT: begin
        if (clear_pulse_i) begin
          digits_d = '0;
          cursor_d = '0;
        end else if (enter_pulse_i) begin
          code_d  = digits_q;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (next_pulse_i) begin
          cursor_d = cursor_adv;
        end else if (inc_pulse_i) begin
          digits_d = digits_inc;
        end
      end
      ST_HOLD: begin
        // Button pulses are deliberately dropped while the code is in flight.
        if (valid_q && code_if.code_ready) begin
          valid_d    = 1'b0;
          attempts_d = attempts_inc;
          digits_d   = '0;
          cursor_d   = '0;
          if (attempts_inc == ATT_W'(MAX_ATTEMPTS)) begin
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end else begin
            state_d  = ST_EDIT;
          end
        end
      end
      ST_LOCKED: begin
        if (clear_pulse_i) begin
          attempts_d = '0;
          locked_d   = 1'b0;
          digits_d   = '0;
          cursor_d   = '0;
          state_d    = ST_EDIT;
        end
      end
      default: begin
        state_d = ST_EDIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EDIT;
      digits_q   <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      cursor_q   <= '0;
      attempts_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      cursor_q   <= cursor_d;
      attempts_q <= attempts_d;
      locked_q   <= locked_d;
    end
  end

  assign code_if.code_valid = valid_q;
  assign code_if.code_out   = code_q;
  assign live_digits_o      = digits_q;
  assign cursor_o           = cursor_q;
  assign attempts_o         = attempts_q;
  assign locked_o           = locked_q;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry: editing, wrap, hold/handshake, priority,
// attempt lockout and asynchronous reset.
module tb_code_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc_p = 1'b0, next_p = 1'b0, enter_p = 1'b0, clear_p = 1'b0;
  logic [15:0] live;
  logic [1:0]  cursor;
  logic [3:0]  attempts;
  logic        locked;

  int vectors = 0;
  int miscompares = 0;

  code_entry_if #(.CODE_W(16)) ifc ();

  code_entry dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc_pulse_i   (inc_p),
    .next_pulse_i  (next_p),
    .enter_pulse_i (enter_p),
    .clear_pulse_i (clear_p),
    .code_if       (ifc.master),
    .live_digits_o (live),
    .cursor_o      (cursor),
    .attempts_o    (attempts),
    .locked_o      (locked)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given pulses; outputs are settled on return.
  task automatic step(input logic i, input logic n, input logic e, input logic c);
    @(negedge clk);
    inc_p = i; next_p = n; enter_p = e; clear_p = c;
    @(posedge clk);
    #1;
    inc_p = 1'b0; next_p = 1'b0; enter_p = 1'b0; clear_p = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(negedge clk);
    ifc.code_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ifc.code_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({ifc.code_valid, ifc.code_out, live, cursor, attempts, locked} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0",
               {ifc.code_valid, ifc.code_out, live, cursor, attempts, locked});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_submit();
    set_ready(1'b1);
    repeat (3) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    vectors++;
    if (live !== 16'h0013) begin
      miscompares++; $display("FAIL basic_live: got %h required 0013", live);
    end
    step(0, 0, 1, 0);
    vectors++;
    if (ifc.code_valid !== 1'b1 || ifc.code_out !== 16'h0013) begin
      miscompares++;
      $display("FAIL basic_valid: got valid=%b code=%h required valid=1 code=0013",
               ifc.code_valid, ifc.code_out);
    end
    step(0, 0, 0, 0);
    vectors++;
    if (ifc.code_valid !== 1'b0 || attempts !== 4'd1 || live !== 16'h0 ||
        cursor !== 2'd0 || ifc.code_out !== 16'h0013) begin
      miscompares++;
      $display("FAIL basic_xfer: got valid=%b att=%0d live=%h cur=%0d code=%h required 0 1 0000 0 0013",
               ifc.code_valid, attempts, live, cursor, ifc.code_out);
    end
    $display("basic submit: code=%h attempts=%0d", ifc.code_out, attempts);
  endtask

  task automatic test_wrap();
    repeat (9) step(1, 0, 0, 0);
    vectors++;
    if (live !== 16'h0009) begin
      miscompares++; $display("FAIL wrap_nine: got %h required 0009", live);
    end
    step(1, 0, 0, 0);
    vectors++;
    if (live !== 16'h0000) begin
      miscompares++; $display("FAIL wrap_digit: got %h required 0000", live);
    end
    repeat (3) step(0, 1, 0, 0);
    vectors++;
    if (cursor !== 2'd3) begin
      miscompares++; $display("FAIL cursor_three: got %0d required 3", cursor);
    end
    step(0, 1, 0, 0);
    vectors++;
    if (cursor !== 2'd0) begin
      miscompares++; $display("FAIL cursor_wrap: got %0d required 0", cursor);
    end
    $display("wrap: live=%h cursor=%0d", live, cursor);
  endtask

  task automatic test_hold();
    logic [3:0] pat_i, pat_n, pat_c;
    pat_i = 4'b1001; pat_n = 4'b0110; pat_c = 4'b0100;
    set_ready(1'b0);
    repeat (2) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(pat_i[k%4], pat_n[k%4], 0, pat_c[k%4]);
      vectors++;
      if (ifc.code_valid !== 1'b1 || ifc.code_out !== 16'h0002 ||
          live !== 16'h0002 || cursor !== 2'd0) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got valid=%b code=%h live=%h cur=%0d required 1 0002 0002 0",
                 k, ifc.code_valid, ifc.code_out, live, cursor);
      end
    end
    set_ready(1'b1);
    step(0, 0, 0, 0);
    vectors++;
    if (ifc.code_valid !== 1'b0 || attempts !== 4'd2) begin
      miscompares++;
      $display("FAIL hold_xfer: got valid=%b att=%0d required 0 2", ifc.code_valid, attempts);
    end
    step(0, 0, 0, 0);
    vectors++;
    if (attempts !== 4'd2) begin
      miscompares++; $display("FAIL hold_single: got att=%0d required 2", attempts);
    end
    $display("hold: attempts=%0d", attempts);
  endtask

  task automatic test_coincide();
    set_ready(1'b0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    vectors++;
    if (ifc.code_valid !== 1'b1 || ifc.code_out !== 16'h0001) begin
      miscompares++;
      $display("FAIL enter_inc: got valid=%b code=%h required 1 0001", ifc.code_valid, ifc.code_out);
    end
    set_ready(1'b1);
    step(0, 0, 0, 0);
    vectors++;
    if (attempts !== 4'd3 || ifc.code_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_inc_xfer: got att=%0d valid=%b required 3 0", attempts, ifc.code_valid);
    end
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    vectors++;
    if (ifc.code_valid !== 1'b0 || live !== 16'h0 || attempts !== 4'd3) begin
      miscompares++;
      $display("FAIL clear_enter: got valid=%b live=%h att=%0d required 0 0000 3",
               ifc.code_valid, live, attempts);
    end
    step(1, 1, 0, 0);
    vectors++;
    if (cursor !== 2'd1 || live !== 16'h0) begin
      miscompares++;
      $display("FAIL next_inc: got cur=%0d live=%h required 1 0000", cursor, live);
    end
    $display("coincide: attempts=%0d cursor=%0d", attempts, cursor);
  endtask

  task automatic test_lock();
    do_reset();
    set_ready(1'b1);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      vectors++;
      if (attempts !== 4'(k) || locked !== (k == 10)) begin
        miscompares++;
        $display("FAIL lock_count[%0d]: got att=%0d locked=%b required %0d %b",
                 k, attempts, locked, k, (k == 10));
      end
    end
    step(0, 0, 1, 0);
    vectors++;
    if (ifc.code_valid !== 1'b0 || attempts !== 4'd10 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_enter: got valid=%b att=%0d locked=%b required 0 10 1",
               ifc.code_valid, attempts, locked);
    end
    step(1, 0, 0, 0);
    vectors++;
    if (live !== 16'h0) begin
      miscompares++; $display("FAIL lock_inc: got %h required 0000", live);
    end
    step(0, 0, 0, 1);
    vectors++;
    if (locked !== 1'b0 || attempts !== 4'd0) begin
      miscompares++;
      $display("FAIL unlock: got locked=%b att=%0d required 0 0", locked, attempts);
    end
    step(1, 0, 0, 0);
    vectors++;
    if (live !== 16'h0001) begin
      miscompares++; $display("FAIL unlock_edit: got %h required 0001", live);
    end
    $display("lock: locked=%b attempts=%0d live=%h", locked, attempts, live);
  endtask

  task automatic test_async_reset();
    set_ready(1'b0);
    step(0, 0, 1, 0);
    vectors++;
    if (ifc.code_valid !== 1'b1) begin
      miscompares++; $display("FAIL areset_pre: got valid=%b required 1", ifc.code_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifc.code_valid, ifc.code_out, live, cursor, attempts, locked} !== 25'd0) begin
      miscompares++;
      $display("FAIL areset_async: got %h required 0",
               {ifc.code_valid, ifc.code_out, live, cursor, attempts, locked});
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    step(0, 0, 0, 0);
    vectors++;
    if (attempts !== 4'd0 || ifc.code_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_nocount: got att=%0d valid=%b required 0 0", attempts, ifc.code_valid);
    end
    step(1, 0, 0, 0);
    vectors++;
    if (live !== 16'h0001) begin
      miscompares++; $display("FAIL areset_edit: got %h required 0001", live);
    end
    $display("async reset: attempts=%0d live=%h", attempts, live);
  endtask

  initial begin
    test_reset();
    test_basic_submit();
    test_wrap();
    test_hold();
    test_coincide();
    test_lock();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
